answer_entry: RTL

ANSWER_ENTRY -- requirements
Module: answer_entry

---
 rtl/answer_entry.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/answer_entry.sv
// Grid answer entry: debounced push buttons drive a cursor over an NxN cell
// bitmap; the finished bitmap is offered to a consumer with a valid/ack handshake.
module answer_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  o_level,
  input  logic        enable,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_select,
  input  logic        btn_submit,
  input  logic        answer_ack,
  output logic [24:0] answer,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic        answer_valid,
  output logic [4:0]  set_count,
  output logic        entry_active
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 select, 5 submit.
  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4, B_SUB = 5;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_SUBMIT} state_t;

  logic [5:0]    w_btn_raw;
  logic [5:0]    r_sync1, r_sync2, r_deb, r_pulse, r_block;
  logic [1:0]    r_sync_vld;
  logic [CW-1:0] r_cnt [6];

  assign w_btn_raw = {btn_submit, btn_select, btn_right, btn_left, btn_down, btn_up};

  // r_block suppresses pulses for buttons already held when reset releases;
  // it clears once the synchronizer shows the real input released.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: the counter array is reset element by element, which is cheap here
  // because it is six small flop registers, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      r_pulse    <= '0;
      r_block    <= '1;
      r_sync_vld <= '0;
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_btn_raw;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      for (int i = 0; i < 6; i++) begin
        r_pulse[i] <= 1'b0;
        if (r_sync_vld[1] && !r_sync2[i]) r_block[i] <= 1'b0;
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_deb[i]   <= r_sync2[i];
            r_cnt[i]   <= '0;
            r_pulse[i] <= r_sync2[i] && !r_block[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  state_t      r_state, w_state_next;
  logic [24:0] r_answer, w_answer_next;
  logic [2:0]  r_row, w_row_next, r_col, w_col_next;
  logic [1:0]  r_level, w_level_next;
  logic        r_valid, w_valid_next;
  logic [4:0]  r_set_count, w_pop;
  logic [2:0]  w_n;
  logic [4:0]  w_nn, w_lin, w_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_answer    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_level     <= '0;
      r_valid     <= 1'b0;
      r_set_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_answer    <= w_answer_next;
      r_row       <= w_row_next;
      r_col       <= w_col_next;
      r_level     <= w_level_next;
      r_valid     <= w_valid_next;
      r_set_count <= w_pop;
    end
  end

  // Cell (r,c) lives at bit N*N-1-(r*N+c): row-major, MSB first.
  always_comb begin
    case (r_level)
      2'b01:   w_n = 3'd3;
      2'b10:   w_n = 3'd4;
      2'b11:   w_n = 3'd5;
      default: w_n = 3'd1;
    endcase
    w_nn  = {2'b00, w_n} * {2'b00, w_n};
    w_lin = {2'b00, r_row} * {2'b00, w_n} + {2'b00, r_col};
    w_idx = w_nn - 5'd1 - w_lin;
    w_pop = '0;
    for (int i = 0; i < 25; i++) w_pop = w_pop + {4'b0000, r_answer[i]};
  end

  // NOTE: every next-state signal gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_answer_next = r_answer;
    w_row_next    = r_row;
    w_col_next    = r_col;
    w_level_next  = r_level;
    w_valid_next  = r_valid;
    case (r_state)
      S_IDLE: begin
        if (enable && o_level != 2'b00) begin
          w_answer_next = '0;
          w_row_next    = '0;
          w_col_next    = '0;
          w_level_next  = o_level;
          w_state_next  = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (!enable || o_level == 2'b00) begin
          w_state_next = S_IDLE;
        end else if (o_level != r_level) begin
          w_answer_next = '0;
          w_row_next    = '0;
          w_col_next    = '0;
          w_level_next  = o_level;
        end else if (r_pulse[B_SUB]) begin
          w_valid_next = 1'b1;
          w_state_next = S_SUBMIT;
        end else if (r_pulse[B_SEL]) begin
          w_answer_next = r_answer ^ (25'd1 << w_idx);
        end else if (r_pulse[B_UP]) begin
          w_row_next = (r_row == 3'd0) ? w_n - 3'd1 : r_row - 3'd1;
        end else if (r_pulse[B_DOWN]) begin
          w_row_next = (r_row == w_n - 3'd1) ? 3'd0 : r_row + 3'd1;
        end else if (r_pulse[B_LEFT]) begin
          w_col_next = (r_col == 3'd0) ? w_n - 3'd1 : r_col - 3'd1;
        end else if (r_pulse[B_RIGHT]) begin
          w_col_next = (r_col == w_n - 3'd1) ? 3'd0 : r_col + 3'd1;
        end
      end
      S_SUBMIT: begin
        if (answer_ack) begin
          w_valid_next = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign answer       = r_answer;
  assign cursor_row   = r_row;
  assign cursor_col   = r_col;
  assign answer_valid = r_valid;
  assign set_count    = r_set_count;
  assign entry_active = (r_state == S_ENTRY);

endmodule
